// File: rtl/cam_rgb565_capture.sv
// Camera byte-stream to RGB565 pixel capture.
// Pairs bytes inside HREF into 16-bit pixels, tracks pixel column/row, and
// flags frames whose geometry does not match H_PIXELS x V_LINES.
module cam_rgb565_capture #(
    parameter int H_PIXELS = 480,
    parameter int V_LINES  = 272,
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        PixelClk,
    input  logic        reset,
    input  logic [7:0]  pixdata,
    input  logic        hsync,
    input  logic        vsync,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [10:0] x_cnt,
    output logic [9:0]  y_cnt,
    output logic        frame_done,
    output logic        frame_err
);

    // Counters saturate one step past the legal size so that an over-long
    // line or frame stays distinguishable from an exactly-sized one.
    localparam logic [10:0] H_LAST = 11'(H_PIXELS - 1);
    localparam logic [10:0] H_END  = 11'(H_PIXELS);
    localparam logic [10:0] H_OVF  = 11'(H_PIXELS + 1);
    localparam logic [10:0] V_END  = 11'(V_LINES);
    localparam logic [10:0] V_OVF  = 11'(V_LINES + 1);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        VBLANK    = 2'd1,
        WAIT_HREF = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  held_q, held_d;
    logic [10:0] col_q, col_d;
    logic [10:0] row_q, row_d;
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        err_set;

    // Next-state, byte pairing, counting and error detection.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        held_d      = held_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        sof_d       = 1'b0;
        eol_d       = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_set     = 1'b0;

        case (state_q)
            SYNC: begin
                phase_d = 1'b0;
                if (vsync) begin
                    state_d = VBLANK;
                end
            end
            VBLANK: begin
                phase_d = 1'b0;
                row_d   = '0;
                if (!vsync) begin
                    state_d = WAIT_HREF;
                    err_d   = 1'b0;
                end
            end
            WAIT_HREF, CAPTURE: begin
                if (vsync) begin
                    // Frame boundary; a line still in HREF is abandoned.
                    state_d = VBLANK;
                    phase_d = 1'b0;
                    done_d  = 1'b1;
                    if (hsync || (row_q != V_END)) begin
                        err_set = 1'b1;
                    end
                end else if (hsync) begin
                    state_d = CAPTURE;
                    if (state_q == WAIT_HREF) begin
                        col_d   = '0;
                        held_d  = pixdata;
                        phase_d = 1'b1;
                    end else if (!phase_q) begin
                        held_d  = pixdata;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if ((col_q < H_END) && (row_q < V_END)) begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = HI_FIRST ? {held_q, pixdata} : {pixdata, held_q};
                            x_d         = col_q;
                            y_d         = row_q[9:0];
                            sof_d       = (col_q == 11'd0) && (row_q == 11'd0);
                            eol_d       = (col_q == H_LAST);
                        end
                        if (col_q != H_OVF) begin
                            col_d = col_q + 11'd1;
                        end
                    end
                end else if (state_q == CAPTURE) begin
                    // End of line: a dangling byte or wrong width is malformed.
                    state_d = WAIT_HREF;
                    phase_d = 1'b0;
                    if (phase_q || (col_q != H_END)) begin
                        err_set = 1'b1;
                    end
                    if (row_q != V_OVF) begin
                        row_d = row_q + 11'd1;
                    end
                end
            end
            default: begin
                state_d = SYNC;
                phase_d = 1'b0;
            end
        endcase

        if (err_set) begin
            err_d = 1'b1;
        end
    end

    // State and output registers; reset clears everything including held byte.
    always_ff @(posedge PixelClk) begin
        if (reset) begin
            state_q     <= SYNC;
            phase_q     <= 1'b0;
            held_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            held_q      <= held_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            x_q         <= x_d;
            y_q         <= y_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sof    = sof_q;
    assign pix_eol    = eol_q;
    assign x_cnt      = x_q;
    assign y_cnt      = y_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_cam_rgb565_capture.sv
// Bench for cam_rgb565_capture: reduced frame geometry, transaction-level model.
module tb_cam_rgb565_capture;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int LB = 2 * H;

    logic        clk;
    logic        reset;
    logic [7:0]  pixdata;
    logic        hsync;
    logic        vsync;
    logic [15:0] pix_data,  pix_data0;
    logic        pix_valid, pix_valid0;
    logic        pix_sof,   pix_sof0;
    logic        pix_eol,   pix_eol0;
    logic [10:0] x_cnt,     x_cnt0;
    logic [9:0]  y_cnt,     y_cnt0;
    logic        frame_done, frame_done0;
    logic        frame_err,  frame_err0;

    cam_rgb565_capture #(.H_PIXELS(H), .V_LINES(V), .HI_FIRST(1'b1)) dut (
        .PixelClk(clk), .reset(reset), .pixdata(pixdata), .hsync(hsync), .vsync(vsync),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_done(frame_done), .frame_err(frame_err));

    cam_rgb565_capture #(.H_PIXELS(H), .V_LINES(V), .HI_FIRST(1'b0)) dut0 (
        .PixelClk(clk), .reset(reset), .pixdata(pixdata), .hsync(hsync), .vsync(vsync),
        .pix_data(pix_data0), .pix_valid(pix_valid0), .pix_sof(pix_sof0), .pix_eol(pix_eol0),
        .x_cnt(x_cnt0), .y_cnt(y_cnt0), .frame_done(frame_done0), .frame_err(frame_err0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected events keyed by the cycle in which the DUT must show them.
    // kind 0 = pixel, 1 = frame_done, 2 = frame_err becomes val, 3 = reset
    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] data;
        int          x;
        int          y;
        bit          sof;
        bit          eol;
        bit          val;
    } ev_t;
    ev_t evq[$];

    task automatic push(input int c, input int k, input logic [15:0] d, input int x,
                        input int y, input bit s, input bit l, input bit v);
        ev_t t;
        t.cyc = c; t.kind = k; t.data = d; t.x = x; t.y = y; t.sof = s; t.eol = l; t.val = v;
        evq.push_back(t);
    endtask

    // Frame model state
    bit capturing = 1'b0;
    int mline = 0;

    int vcount = 0;
    int dcount = 0;

    // Compare process: every cycle after the first reset
    initial begin
        bit          chk_en;
        bit          e_valid, e_done, e_sof, e_eol, e_err;
        logic [15:0] e_data;
        int          e_x, e_y;
        ev_t         ev;
        chk_en = 1'b0; e_data = '0; e_x = 0; e_y = 0; e_err = 1'b0;
        forever begin
            @(negedge clk);
            e_valid = 1'b0; e_done = 1'b0; e_sof = 1'b0; e_eol = 1'b0;
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                ev = evq.pop_front();
                if (ev.cyc < cyc) chk("event_timing", ev.cyc, cyc);
                case (ev.kind)
                    0: begin
                        e_valid = 1'b1; e_data = ev.data; e_x = ev.x; e_y = ev.y;
                        e_sof = ev.sof; e_eol = ev.eol;
                    end
                    1: e_done = 1'b1;
                    2: e_err = ev.val;
                    default: begin
                        chk_en = 1'b1; e_data = '0; e_x = 0; e_y = 0; e_err = 1'b0;
                    end
                endcase
            end
            if (chk_en) begin
                chk("pix_valid", pix_valid, e_valid);
                chk("pix_data", pix_data, e_data);
                chk("x_cnt", x_cnt, e_x);
                chk("y_cnt", y_cnt, e_y);
                chk("pix_sof", pix_sof, e_sof);
                chk("pix_eol", pix_eol, e_eol);
                chk("frame_done", frame_done, e_done);
                chk("frame_err", frame_err, e_err);
                chk("pix_valid_lofirst", pix_valid0, e_valid);
                chk("pix_data_lofirst", pix_data0, {e_data[7:0], e_data[15:8]});
                if (pix_valid) vcount++;
                if (frame_done) dcount++;
            end
        end
    end

    // Inputs change 1 time unit after a rising edge; e = cycle in which effect shows
    task automatic drive(input bit r, input bit vs, input bit hs, input logic [7:0] b, output int e);
        @(posedge clk);
        #1;
        reset = r; vsync = vs; hsync = hs; pixdata = b;
        e = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'($urandom), e);
    endtask

    task automatic do_reset(input int n, input bit hs);
        int e;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, hs, 8'($urandom), e);
            push(e, 3, '0, 0, 0, 1'b0, 1'b0, 1'b0);
        end
        capturing = 1'b0;
        mline = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_x"}, x_cnt, 0);
        chk({tag, "_y"}, y_cnt, 0);
        chk({tag, "_sof"}, pix_sof, 0);
        chk({tag, "_eol"}, pix_eol, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_err"}, frame_err, 0);
    endtask

    // One HREF line of nbytes, then gap idle cycles (gap 0 leaves HREF high).
    // pin_y >= 0 adds literal checks on the line's first and last pixel.
    task automatic send_line(input int nbytes, input int gap, input int pin_y);
        int e, p;
        logic [7:0] b, prev;
        prev = '0;
        for (int k = 0; k < nbytes; k++) begin
            b = 8'($urandom);
            if (pin_y == 0 && k == 0) b = 8'hF8;
            if (pin_y == 0 && k == 1) b = 8'h1F;
            drive(1'b0, 1'b0, 1'b1, b, e);
            if ((k % 2) == 1) begin
                p = k / 2;
                if (capturing && p < H && mline < V)
                    push(e, 0, {prev, b}, p, mline, (p == 0 && mline == 0), (p == H - 1), 1'b0);
            end
            prev = b;
            if (pin_y == 0 && k == 2) begin
                chk("lit_first_valid", pix_valid, 1);
                chk("lit_F81F", pix_data, 16'hF81F);
                chk("lit_1FF8", pix_data0, 16'h1FF8);
                chk("lit_sof", pix_sof, 1);
                chk("lit_sof_x", x_cnt, 0);
                chk("lit_sof_y", y_cnt, 0);
            end
        end
        for (int g = 0; g < gap; g++) begin
            drive(1'b0, 1'b0, 1'b0, 8'($urandom), e);
            if (g == 0 && nbytes > 0 && capturing) begin
                if ((nbytes % 2) != 0 || (nbytes / 2) != H) push(e, 2, '0, 0, 0, 1'b0, 1'b0, 1'b1);
                mline++;
            end
            if (g == 0 && pin_y >= 0) begin
                chk("lit_eol", pix_eol, 1);
                chk("lit_eol_x", x_cnt, 15);
                chk("lit_eol_y", y_cnt, pin_y);
            end
        end
    endtask

    // vsync pulse of hi cycles; hs_first keeps HREF high in the first one.
    // err_lit >= 0 checks frame_done/frame_err literally and the clear after exit.
    task automatic vsync_pulse(input int hi, input bit hs_first, input int err_lit);
        int e;
        for (int i = 0; i < hi; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? hs_first : 1'b0, 8'($urandom), e);
            if (i == 0 && capturing) begin
                push(e, 1, '0, 0, 0, 1'b0, 1'b0, 1'b0);
                if (hs_first || mline != V) push(e, 2, '0, 0, 0, 1'b0, 1'b0, 1'b1);
            end
            if (i == 1 && err_lit >= 0) begin
                chk("lit_done", frame_done, 1);
                chk("lit_done_err", frame_err, err_lit);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'($urandom), e);
        if (hi == 1 && err_lit >= 0) begin
            chk("lit_done", frame_done, 1);
            chk("lit_done_err", frame_err, err_lit);
        end
        push(e, 2, '0, 0, 0, 1'b0, 1'b0, 1'b0);
        capturing = 1'b1;
        mline = 0;
        drive(1'b0, 1'b0, 1'b0, 8'($urandom), e);
        if (err_lit >= 0) chk("lit_err_cleared", frame_err, 0);
    endtask

    task automatic normal_frame(input int pins);
        for (int l = 0; l < V; l++)
            send_line(LB, 2, (pins != 0 && l == 0) ? 0 : ((pins != 0 && l == V - 1) ? V - 1 : -1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: time %0t exceeded limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        int v0, d0, nl, nb, r;
        reset = 1'b1; vsync = 1'b0; hsync = 1'b0; pixdata = '0;

        do_reset(3, 1'b0);
        idle(1);
        chk_zero("reset");

        // Partial frame before any vsync pulse is ignored
        for (int l = 0; l < V; l++) send_line(LB, 2, -1);
        idle(2);
        chk("partial_pixels", vcount, 0);
        chk("partial_done", dcount, 0);

        // First complete frame
        vsync_pulse(3, 1'b0, -1);
        v0 = vcount; d0 = dcount;
        normal_frame(1);
        vsync_pulse(2, 1'b0, 0);
        idle(2);
        chk("full_frame_pixels", vcount - v0, 96);
        chk("full_frame_done", dcount - d0, 1);

        // Odd-length line (33 bytes), then a clean frame clears the flag
        send_line(LB, 2, -1); send_line(LB, 2, -1);
        send_line(LB + 1, 2, -1);
        for (int l = 3; l < V; l++) send_line(LB, 2, -1);
        vsync_pulse(2, 1'b0, 1);
        normal_frame(0);
        vsync_pulse(2, 1'b0, 0);

        // Over-long line (40 bytes) emits exactly H pixels
        send_line(LB, 2, -1);
        idle(1);
        v0 = vcount;
        send_line(40, 2, -1);
        chk("long_line_pixels", vcount - v0, 16);
        for (int l = 2; l < V; l++) send_line(LB, 2, -1);
        vsync_pulse(2, 1'b0, 1);

        // Frame with V+1 lines: only V emitted
        v0 = vcount;
        for (int l = 0; l < V + 1; l++) send_line(LB, 2, -1);
        idle(2);
        chk("tall_frame_pixels", vcount - v0, 96);
        vsync_pulse(2, 1'b0, 1);

        // vsync rises inside HREF
        for (int l = 0; l < 3; l++) send_line(LB, 2, -1);
        send_line(10, 0, -1);
        vsync_pulse(2, 1'b1, 1);

        // Reset mid-line with a phase-1 byte on the wire
        send_line(LB, 1, -1);
        send_line(5, 0, -1);
        do_reset(2, 1'b1);
        chk_zero("midline_reset");
        v0 = vcount;
        send_line(LB, 2, -1);
        send_line(LB, 2, -1);
        idle(2);
        chk("after_reset_pixels", vcount - v0, 0);
        vsync_pulse(2, 1'b0, -1);
        normal_frame(0);
        vsync_pulse(2, 1'b0, 0);

        // Randomized frames
        for (int f = 0; f < 14; f++) begin
            nl = $urandom_range(V - 1, V + 1);
            for (int l = 0; l < nl; l++) begin
                r = $urandom_range(0, 9);
                if (r < 7) nb = LB;
                else if (r == 7) nb = $urandom_range(LB - 3, LB + 3);
                else nb = $urandom_range(0, 45);
                send_line(nb, $urandom_range(1, 3), -1);
            end
            if ($urandom_range(0, 4) == 0) begin
                send_line($urandom_range(0, 12), 0, -1);
                vsync_pulse($urandom_range(1, 3), 1'b1, -1);
            end else begin
                vsync_pulse($urandom_range(1, 3), 1'b0, -1);
            end
        end

        idle(4);
        chk("events_drained", evq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cam_rgb565_capture.md
CAM_RGB565_CAPTURE -- requirements
Module: cam_rgb565_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 480, meaning pixels per active line.
REQ-002 SHALL have parameter V_LINES, default 272, meaning active lines per frame.
REQ-003 SHALL have parameter HI_FIRST, default 1: 1 means the first byte of a pair is RGB565[15:8]; 0 means it is [7:0].
REQ-004 SHALL have port PixelClk, input, 1 bit: single clock (camera pixel clock); all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port pixdata, input, 8 bits: camera data byte.
REQ-007 SHALL have port hsync, input, 1 bit: camera HREF, high during active line bytes.
REQ-008 SHALL have port vsync, input, 1 bit: camera frame sync, high pulse during vertical blanking.
REQ-009 SHALL have port pix_data, output, 16 bits: assembled RGB565 pixel.
REQ-010 SHALL have port pix_valid, output, 1 bit: one-cycle strobe qualifying pix_data.
REQ-011 SHALL have port pix_sof, output, 1 bit: high with pix_valid on pixel (0,0).
REQ-012 SHALL have port pix_eol, output, 1 bit: high with pix_valid on pixel x=H_PIXELS-1.
REQ-013 SHALL have port x_cnt, output, 11 bits: column of the current pix_data.
REQ-014 SHALL have port y_cnt, output, 10 bits: row of the current pix_data.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse at end of a captured frame.
REQ-016 SHALL have port frame_err, output, 1 bit: sticky malformed-frame flag.

Function
REQ-017 SHALL implement states SYNC (wait vsync=1), VBLANK (wait vsync=0), WAIT_HREF, CAPTURE.
REQ-018 Transitions SHALL be: SYNC->VBLANK on vsync=1; VBLANK->WAIT_HREF on vsync=0; WAIT_HREF->CAPTURE on hsync=1; CAPTURE->WAIT_HREF on hsync=0; WAIT_HREF or CAPTURE->VBLANK on vsync=1.
REQ-019 SHALL discard all data before the first complete vsync pulse after reset (partial frame).
REQ-020 In CAPTURE, the byte phase SHALL toggle on each cycle with hsync=1, starting at phase 0 on the first hsync=1 cycle of a line.
REQ-021 The phase-0 byte SHALL be held.
REQ-022 On the phase-1 byte, pix_data SHALL be {held,pixdata} (HI_FIRST=1) or {pixdata,held} (HI_FIRST=0).
REQ-023 pix_valid SHALL assert for exactly one cycle, in the cycle after the phase-1 byte is sampled (latency 1 cycle).
REQ-024 pix_data, x_cnt and y_cnt SHALL remain stable until the next pix_valid.
REQ-025 x_cnt SHALL reset to 0 at each line start and increment after each emitted pixel.
REQ-026 y_cnt SHALL increment on each CAPTURE->WAIT_HREF transition and reset to 0 in VBLANK.
REQ-027 Pixels with x≥H_PIXELS or lines with y≥V_LINES SHALL be dropped: no pix_valid, and counters saturate.
REQ-028 frame_done SHALL pulse one cycle on the transition into VBLANK from WAIT_HREF or CAPTURE; it SHALL NOT pulse from SYNC.
REQ-029 frame_err SHALL set when any of the following occurs:
- hsync falls at phase 1, i.e. an odd byte count (the dangling byte is discarded);
- a line ends with x_cnt≠H_PIXELS;
- a frame ends with line count≠V_LINES;
- vsync rises while hsync=1 (the line is aborted and no further pixels are emitted).
REQ-030 frame_err SHALL clear on the VBLANK->WAIT_HREF transition, after frame_done has been observed.
REQ-031 If an error and frame_done occur in the same cycle, frame_err SHALL be 1 in the cycle frame_done is high.

Reset
REQ-032 reset=1 SHALL force state SYNC and phase 0.
REQ-033 reset=1 SHALL drive all outputs to 0 (pix_data=16'h0000, x_cnt=0, y_cnt=0, frame_err=0) in the cycle after it is sampled.
REQ-034 reset asserted mid-line SHALL discard the held byte, with no pix_valid on the following cycle.
REQ-035 reset SHALL take priority over all other inputs.

Verification
REQ-036 SHALL cover: after reset, a partial frame (no leading vsync) of 480x272 pixels -> zero pix_valid and no frame_done; the following full frame -> 130560 pix_valid and one frame_done.
REQ-037 SHALL cover: HI_FIRST=1, bytes 8'hF8,8'h1F -> pix_data=16'hF81F one cycle after 8'h1F is sampled; with HI_FIRST=0, the same bytes -> 16'h1FF8.
REQ-038 SHALL cover: line 0 pixel 0 -> pix_sof=1, x_cnt=0, y_cnt=0; pixel 479 -> pix_eol=1, x_cnt=479; line 271 last pixel -> y_cnt=271.
REQ-039 SHALL cover: a line of 961 bytes -> 480 pixels emitted, the last byte dropped, frame_err=1 at frame_done, cleared after the next VBLANK exit.
REQ-040 SHALL cover: a line of 1000 bytes -> exactly 480 pix_valid and frame_err=1; a frame of 273 lines -> 272 lines emitted and frame_err=1.
REQ-041 SHALL cover: reset asserted mid-line at phase 1 -> no pix_valid, all outputs 0, and capture resumes only after the next complete vsync pulse.
